cdb_arbiter: RTL

//  Shares the single ROB result write-back bus (CDB) between the ALU and LSB result producers.

---
 rtl/cdb_arbiter_if.sv | 47 ++++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: handshake and bus bundle for the CDB arbiter.
//   rdy_in/clear      global enable and ROB flush
//   alu_*             ALU result producer (valid/tag/value/npc, ready back)
//   lsb_*             LSB load result producer (valid/tag/value, ready back)
//   cdb_*             registered common data bus broadcast
//   err_overflow      sticky push-while-full flag
// master: the side that drives producers and consumes the CDB.
// slave:  the arbiter itself.
interface cdb_arbiter_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              rdy_in;
    logic              clear;
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_value;
    logic [ADDR_W-1:0] alu_npc;
    logic              alu_ready;
    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_value;
    logic              lsb_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [ADDR_W-1:0] cdb_npc;
    logic              cdb_has_npc;
    logic              err_overflow;

    modport master (
        output rdy_in, clear,
        output alu_valid, alu_tag, alu_value, alu_npc,
        output lsb_valid, lsb_tag, lsb_value,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_npc, cdb_has_npc, err_overflow
    );

    modport slave (
        input  rdy_in, clear,
        input  alu_valid, alu_tag, alu_value, alu_npc,
        input  lsb_valid, lsb_tag, lsb_value,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_npc, cdb_has_npc, err_overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the ROB write-back bus (CDB) between the ALU and LSB.
// Each producer pushes into its own DEPTH-entry FIFO; a round-robin arbiter
// pops one head per cycle onto a registered CDB.
// Ports:
//   clk_in  clock
//   rst_in  synchronous active-high reset
//   bus     cdb_arbiter_if.slave (enable, flush, producer handshakes, CDB out)
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic          clk_in,
    input  logic          rst_in,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

    logic [TAG_W-1:0]  alu_tag_q [DEPTH];
    logic [DATA_W-1:0] alu_val_q [DEPTH];
    logic [ADDR_W-1:0] alu_npc_q [DEPTH];
    logic [TAG_W-1:0]  lsb_tag_q [DEPTH];
    logic [DATA_W-1:0] lsb_val_q [DEPTH];

    logic [PTR_W-1:0] alu_wr, alu_rd, lsb_wr, lsb_rd;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    src_e             rr_last;

    logic              cdb_valid, cdb_has_npc, err_overflow;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic [ADDR_W-1:0] cdb_npc;

    logic active, alu_rdy, lsb_rdy, alu_push, lsb_push, alu_pop, lsb_pop;
    logic grant_alu, ovf;

    always_comb begin
        active    = bus.rdy_in & ~bus.clear;
        // Ready looks at the count only, so a pop in the same edge never opens a slot.
        alu_rdy   = active & (alu_cnt < CNT_W'(DEPTH));
        lsb_rdy   = active & (lsb_cnt < CNT_W'(DEPTH));
        alu_push  = bus.alu_valid & alu_rdy & (bus.alu_tag != '0);
        lsb_push  = bus.lsb_valid & lsb_rdy & (bus.lsb_tag != '0);
        // ALU wins when it is the only one with data, or on a tie when LSB went last.
        grant_alu = (alu_cnt != '0) & ((lsb_cnt == '0) | (rr_last == SRC_LSB));
        alu_pop   = active & grant_alu;
        lsb_pop   = active & ~grant_alu & (lsb_cnt != '0);
        ovf       = active & ((bus.alu_valid & ~alu_rdy) | (bus.lsb_valid & ~lsb_rdy));
    end

    // Storage carries no reset; the counts decide what is live.
    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_tag_q[alu_wr] <= bus.alu_tag;
            alu_val_q[alu_wr] <= bus.alu_value;
            alu_npc_q[alu_wr] <= bus.alu_npc;
        end
        if (lsb_push) begin
            lsb_tag_q[lsb_wr] <= bus.lsb_tag;
            lsb_val_q[lsb_wr] <= bus.lsb_value;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_wr       <= '0;
            alu_rd       <= '0;
            alu_cnt      <= '0;
            lsb_wr       <= '0;
            lsb_rd       <= '0;
            lsb_cnt      <= '0;
            rr_last      <= SRC_LSB;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
            cdb_npc      <= '0;
            cdb_has_npc  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (ovf) err_overflow <= 1'b1;
            if (bus.clear) begin
                alu_wr      <= '0;
                alu_rd      <= '0;
                alu_cnt     <= '0;
                lsb_wr      <= '0;
                lsb_rd      <= '0;
                lsb_cnt     <= '0;
                cdb_valid   <= 1'b0;
                cdb_tag     <= '0;
                cdb_value   <= '0;
                cdb_npc     <= '0;
                cdb_has_npc <= 1'b0;
            end else if (!bus.rdy_in) begin
                cdb_valid <= 1'b0;
            end else begin
                if (alu_push) alu_wr <= alu_wr + 1'b1;
                if (alu_pop)  alu_rd <= alu_rd + 1'b1;
                if (lsb_push) lsb_wr <= lsb_wr + 1'b1;
                if (lsb_pop)  lsb_rd <= lsb_rd + 1'b1;
                alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
                lsb_cnt <= lsb_cnt + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
                if (alu_pop) begin
                    cdb_valid   <= 1'b1;
                    cdb_tag     <= alu_tag_q[alu_rd];
                    cdb_value   <= alu_val_q[alu_rd];
                    cdb_npc     <= alu_npc_q[alu_rd];
                    cdb_has_npc <= 1'b1;
                    rr_last     <= SRC_ALU;
                end else if (lsb_pop) begin
                    cdb_valid   <= 1'b1;
                    cdb_tag     <= lsb_tag_q[lsb_rd];
                    cdb_value   <= lsb_val_q[lsb_rd];
                    cdb_npc     <= '0;
                    cdb_has_npc <= 1'b0;
                    rr_last     <= SRC_LSB;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.alu_ready    = alu_rdy;
    assign bus.lsb_ready    = lsb_rdy;
    assign bus.cdb_valid    = cdb_valid;
    assign bus.cdb_tag      = cdb_tag;
    assign bus.cdb_value    = cdb_value;
    assign bus.cdb_npc      = cdb_npc;
    assign bus.cdb_has_npc  = cdb_has_npc;
    assign bus.err_overflow = err_overflow;
endmodule
